// File: rtl/dual_issue_scheduler.sv
// Two-slot issue controller: a small circular instruction queue feeding slots A/B, holding back
// the younger slot on intra-pair, structural and control hazards and bubbling load-use reads.
module dual_issue_scheduler #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CW     = $clog2(QDEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          fetch_valid_i,
  input  logic          fetch_b_valid_i,
  input  logic [31:0]   fetch_instr_a_i,
  input  logic [31:0]   fetch_instr_b_i,
  output logic          fetch_ready_o,
  input  logic          issue_ready_i,
  input  logic          flush_i,
  output logic          issue_a_valid_o,
  output logic [31:0]   issue_a_instr_o,
  output logic          issue_b_valid_o,
  output logic [31:0]   issue_b_instr_o,
  output logic [1:0]    stall_cause_o,
  output logic [CW-1:0] q_count_o
);

  localparam int unsigned PW = $clog2(QDEPTH);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  // Writes to x0 are folded in here so no hazard check ever sees them.
  function automatic logic writes_rd(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == OpLoad || op == OpImm || op == OpJal || op == OpReg) && (ins[11:7] != 5'd0);
  endfunction

  function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [6:0] op;
    logic       rs1_used, rs2_used;
    op       = ins[6:0];
    rs1_used = (op == OpLoad || op == OpImm || op == OpStore || op == OpBranch || op == OpReg);
    rs2_used = (op == OpStore || op == OpBranch || op == OpReg);
    return (rs1_used && ins[19:15] == r) || (rs2_used && ins[24:20] == r);
  endfunction

  function automatic logic is_mem(input logic [31:0] ins);
    return ins[6:0] == OpLoad || ins[6:0] == OpStore;
  endfunction

  function automatic logic is_ctrl(input logic [31:0] ins);
    return ins[6:0] == OpBranch || ins[6:0] == OpJal;
  endfunction

  logic [31:0]   mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trk_a_v_q, trk_a_v_d, trk_b_v_q, trk_b_v_d;
  logic [4:0]    trk_a_rd_q, trk_a_rd_d, trk_b_rd_q, trk_b_rd_d;

  logic [31:0] head0, head1;
  logic        lu0, lu1, dep, structural;
  logic        a_ok, b_ok, push_a, push_b;
  logic [1:0]  cause, n_push, n_pop;

  always_comb begin
    head0 = mem_q[rd_ptr_q];
    head1 = mem_q[rd_ptr_q + PW'(1)];

    lu0 = (trk_a_v_q && reads_reg(head0, trk_a_rd_q)) ||
          (trk_b_v_q && reads_reg(head0, trk_b_rd_q));
    // A younger read of an older same-pair load's result is a load-use, not a plain RAW.
    lu1 = (trk_a_v_q && reads_reg(head1, trk_a_rd_q)) ||
          (trk_b_v_q && reads_reg(head1, trk_b_rd_q)) ||
          (head0[6:0] == OpLoad && writes_rd(head0) && reads_reg(head1, head0[11:7]));
    dep = writes_rd(head0) &&
          (reads_reg(head1, head0[11:7]) || (writes_rd(head1) && head1[11:7] == head0[11:7]));
    structural = (is_mem(head0) && is_mem(head1)) || is_ctrl(head0);

    a_ok  = 1'b0;
    b_ok  = 1'b0;
    cause = 2'd0;
    if (!reset_i && !flush_i && cnt_q != '0) begin
      if (lu0) begin
        cause = 2'd1;
      end else begin
        a_ok = 1'b1;
        if (cnt_q >= CW'(2)) begin
          if (lu1)             cause = 2'd1;
          else if (dep)        cause = 2'd2;
          else if (structural) cause = 2'd3;
          else                 b_ok  = 1'b1;
        end
      end
    end

    fetch_ready_o   = !reset_i && !flush_i && ((CW'(QDEPTH) - cnt_q) >= CW'(2));
    issue_a_valid_o = a_ok;
    issue_a_instr_o = a_ok ? head0 : 32'd0;
    issue_b_valid_o = b_ok;
    issue_b_instr_o = b_ok ? head1 : 32'd0;
    stall_cause_o   = cause;
    q_count_o       = cnt_q;

    push_a = fetch_valid_i && fetch_ready_o;
    push_b = push_a && fetch_b_valid_i;
    n_push = {1'b0, push_a} + {1'b0, push_b};
    n_pop  = issue_ready_i ? ({1'b0, a_ok} + {1'b0, b_ok}) : 2'd0;

    wr_ptr_d = wr_ptr_q + PW'(n_push);
    rd_ptr_d = rd_ptr_q + PW'(n_pop);
    cnt_d    = cnt_q + CW'(n_push) - CW'(n_pop);

    trk_a_v_d  = trk_a_v_q;
    trk_a_rd_d = trk_a_rd_q;
    trk_b_v_d  = trk_b_v_q;
    trk_b_rd_d = trk_b_rd_q;
    if (issue_ready_i) begin
      trk_a_v_d  = a_ok && head0[6:0] == OpLoad && head0[11:7] != 5'd0;
      trk_a_rd_d = head0[11:7];
      trk_b_v_d  = b_ok && head1[6:0] == OpLoad && head1[11:7] != 5'd0;
      trk_b_rd_d = head1[11:7];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      trk_a_v_q  <= 1'b0;
      trk_a_rd_q <= 5'd0;
      trk_b_v_q  <= 1'b0;
      trk_b_rd_q <= 5'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      trk_a_v_q  <= trk_a_v_d;
      trk_a_rd_q <= trk_a_rd_d;
      trk_b_v_q  <= trk_b_v_d;
      trk_b_rd_q <= trk_b_rd_d;
    end
  end

  // Storage needs no reset; pushes are already blocked during reset and flush.
  always_ff @(posedge clk_i) begin
    if (push_a) mem_q[wr_ptr_q] <= fetch_instr_a_i;
    if (push_b) mem_q[wr_ptr_q + PW'(1)] <= fetch_instr_b_i;
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench: stimulus queues hand-computed expectations per cycle; a monitor compares them.
module tb_dual_issue_scheduler;

  localparam logic [31:0] ADDI1 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] ADDI5 = 32'h00100293;  // addi x5,x0,1
  localparam logic [31:0] ADDI3 = 32'h00700193;  // addi x3,x0,7
  localparam logic [31:0] ADDI4 = 32'h00900213;  // addi x4,x0,9
  localparam logic [31:0] ADD2  = 32'h00108133;  // add x2,x1,x1
  localparam logic [31:0] LW3   = 32'h00002183;  // lw x3,0(x0)
  localparam logic [31:0] ADD4  = 32'h00018233;  // add x4,x3,x0
  localparam logic [31:0] SW1   = 32'h00102023;  // sw x1,0(x0)
  localparam logic [31:0] BEQ   = 32'h00000063;  // beq x0,x0,0

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0, fetch_b_valid = 1'b0;
  logic [31:0] fetch_instr_a = '0, fetch_instr_b = '0;
  logic        fetch_ready;
  logic        issue_ready = 1'b0, flush = 1'b0;
  logic        a_valid, b_valid;
  logic [31:0] a_instr, b_instr;
  logic [1:0]  stall_cause;
  logic [2:0]  q_count;

  dual_issue_scheduler #(.QDEPTH(4)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .fetch_valid_i  (fetch_valid),
    .fetch_b_valid_i(fetch_b_valid),
    .fetch_instr_a_i(fetch_instr_a),
    .fetch_instr_b_i(fetch_instr_b),
    .fetch_ready_o  (fetch_ready),
    .issue_ready_i  (issue_ready),
    .flush_i        (flush),
    .issue_a_valid_o(a_valid),
    .issue_a_instr_o(a_instr),
    .issue_b_valid_o(b_valid),
    .issue_b_instr_o(b_instr),
    .stall_cause_o  (stall_cause),
    .q_count_o      (q_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        av;
    logic [31:0] ai;
    logic        bv;
    logic [31:0] bi;
    logic [1:0]  cause;
    int          cnt;
    logic        fr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, after inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("expect_cycle", cyc, e.cyc);
        chk("a_valid", {31'd0, a_valid}, {31'd0, e.av});
        chk("a_instr", a_instr, e.ai);
        chk("b_valid", {31'd0, b_valid}, {31'd0, e.bv});
        chk("b_instr", b_instr, e.bi);
        chk("stall_cause", {30'd0, stall_cause}, {30'd0, e.cause});
        chk("q_count", {29'd0, q_count}, e.cnt);
        chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, e.fr});
      end
    end
  end

  task automatic s(input logic fv, input logic fbv, input logic [31:0] ia, input logic [31:0] ib,
                   input logic ir, input logic fl, input logic rs,
                   input logic eav, input logic [31:0] eai, input logic ebv,
                   input logic [31:0] ebi, input logic [1:0] ec, input int ecnt, input logic efr);
    exp_t e;
    @(posedge clk);
    #1;
    fetch_valid   = fv;
    fetch_b_valid = fbv;
    fetch_instr_a = ia;
    fetch_instr_b = ib;
    issue_ready   = ir;
    flush         = fl;
    reset         = rs;
    e.cyc = cyc; e.av = eav; e.ai = eai; e.bv = ebv; e.bi = ebi;
    e.cause = ec; e.cnt = ecnt; e.fr = efr;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset, then idle
    s(0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 0, 0,   0, 0);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 0,   0, 1);
    // Independent pair
    s(1, 1, ADDI1, ADDI5, 1, 0, 0, 0, 0, 0, 0, 0,    0, 1);
    s(0, 0, 0, 0,   1, 0, 0,   1, ADDI1, 1, ADDI5, 0, 2, 1);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 0,   0, 1);
    // Intra-pair RAW
    s(1, 1, ADDI1, ADD2, 1, 0, 0, 0, 0, 0, 0, 0,     0, 1);
    s(0, 0, 0, 0,   1, 0, 0,   1, ADDI1, 0, 0, 2, 2, 1);
    s(0, 0, 0, 0,   1, 0, 0,   1, ADD2, 0, 0, 0,  1, 1);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 0,   0, 1);
    // Load-use: hold B, one bubble, then issue
    s(1, 1, LW3, ADD4, 1, 0, 0, 0, 0, 0, 0, 0,      0, 1);
    s(0, 0, 0, 0,   1, 0, 0,   1, LW3, 0, 0, 1,   2, 1);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 1,     1, 1);
    s(0, 0, 0, 0,   1, 0, 0,   1, ADD4, 0, 0, 0,  1, 1);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 0,     0, 1);
    // Structural: two memory ops
    s(1, 1, LW3, SW1, 1, 0, 0,  0, 0, 0, 0, 0,     0, 1);
    s(0, 0, 0, 0,   1, 0, 0,   1, LW3, 0, 0, 3,   2, 1);
    s(0, 0, 0, 0,   1, 0, 0,   1, SW1, 0, 0, 0,   1, 1);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 0,     0, 1);
    // Control: branch in head0
    s(1, 1, BEQ, ADDI1, 1, 0, 0, 0, 0, 0, 0, 0,    0, 1);
    s(0, 0, 0, 0,   1, 0, 0,   1, BEQ, 0, 0, 3,   2, 1);
    s(0, 0, 0, 0,   1, 0, 0,   1, ADDI1, 0, 0, 0, 1, 1);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 0,     0, 1);
    // Backpressure to full, drop while full, drain across the pointer wrap
    s(1, 1, ADDI1, ADDI5, 0, 0, 0, 0, 0, 0, 0, 0,       0, 1);
    s(1, 1, ADDI3, ADDI4, 0, 0, 0, 1, ADDI1, 1, ADDI5, 0, 2, 1);
    s(0, 0, 0, 0,   0, 0, 0,   1, ADDI1, 1, ADDI5, 0,   4, 0);
    s(1, 1, LW3, SW1, 0, 0, 0,  1, ADDI1, 1, ADDI5, 0,   4, 0);
    s(0, 0, 0, 0,   1, 0, 0,   1, ADDI1, 1, ADDI5, 0,   4, 0);
    s(0, 0, 0, 0,   1, 0, 0,   1, ADDI3, 1, ADDI4, 0,   2, 1);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 0,           0, 1);
    // Single-word push, then flush with a concurrent push at q_count 3
    s(1, 0, ADDI1, 0, 0, 0, 0,   0, 0, 0, 0, 0,           0, 1);
    s(1, 1, ADDI3, ADDI4, 0, 0, 0, 1, ADDI1, 0, 0, 0,    1, 1);
    s(0, 0, 0, 0,   0, 0, 0,   1, ADDI1, 1, ADDI3, 0,   3, 0);
    s(1, 1, ADDI5, ADDI5, 0, 1, 0, 0, 0, 0, 0, 0,        3, 0);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 0,           0, 1);
    // Reset mid-stream with a concurrent push
    s(1, 1, ADDI1, ADDI5, 0, 0, 0, 0, 0, 0, 0, 0,        0, 1);
    s(1, 0, ADDI3, 0, 0, 0, 0,   1, ADDI1, 1, ADDI5, 0, 2, 1);
    s(1, 1, ADDI4, ADDI4, 1, 0, 1, 0, 0, 0, 0, 0,        3, 0);
    s(0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 0,           0, 1);
    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
